// File: rtl/mrv_pkg.sv
// Shared definitions for the mrv memory subsystem: arbiter owner encoding.
package mrv_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t ARB_NONE = 2'd0;
    localparam owner_t ARB_IMEM = 2'd1;
    localparam owner_t ARB_DMEM = 2'd2;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED_I = 2'd1,
        LOCKED_D = 2'd2
    } lock_state_t;

endpackage

// File: rtl/mrv_mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto one shared memory port.
// Define MRV_ARB_RR_EN for round-robin contention; default is dmem-wins priority.
module mrv_mem_arbiter
    import mrv_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        imem_cen,
    input  logic        imem_wen,
    input  logic [3:0]  imem_strb,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    output logic        imem_stall,
    output logic        imem_error,
    output logic [31:0] imem_rdata,

    input  logic        dmem_cen,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_stall,
    output logic        dmem_error,
    output logic [31:0] dmem_rdata,

    output logic        mem_cen,
    output logic        mem_wen,
    output logic [3:0]  mem_strb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_stall,
    input  logic        mem_error,
    input  logic [31:0] mem_rdata,

    output logic [1:0]  arb_owner
);

    lock_state_t state, state_nxt;
    logic        lock_valid;
    logic        lock_owner;   // 0 imem, 1 dmem
    logic        last_grant;   // 0 imem, 1 dmem
    logic        grant_i, grant_d, grant_any;
    logic        lock_hold;

    assign lock_valid = (state != UNLOCKED);
    assign lock_owner = (state == LOCKED_D);
    assign grant_any  = grant_i | grant_d;

    // A lock only holds while its owner keeps cen high; otherwise re-arbitrate now.
    assign lock_hold = lock_valid && (lock_owner ? dmem_cen : imem_cen);

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!g_reset) begin
            if (lock_hold) begin
                grant_i = ~lock_owner;
                grant_d = lock_owner;
            end else if (imem_cen && dmem_cen) begin
`ifdef MRV_ARB_RR_EN
                grant_i = last_grant;
                grant_d = ~last_grant;
`else
                grant_d = 1'b1;
`endif
            end else begin
                grant_i = imem_cen;
                grant_d = dmem_cen;
            end
        end
    end

    always_comb begin
        mem_cen    = 1'b0;
        mem_wen    = 1'b0;
        mem_strb   = 4'd0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        arb_owner  = ARB_NONE;
        imem_stall = 1'b0;
        imem_error = 1'b0;
        imem_rdata = 32'd0;
        dmem_stall = 1'b0;
        dmem_error = 1'b0;
        dmem_rdata = 32'd0;

        if (g_reset) begin
            imem_stall = 1'b1;
            dmem_stall = 1'b1;
        end else begin
            if (grant_i) begin
                mem_cen    = 1'b1;
                mem_wen    = imem_wen;
                mem_strb   = imem_strb;
                mem_addr   = imem_addr;
                mem_wdata  = imem_wdata;
                arb_owner  = ARB_IMEM;
                imem_stall = mem_stall;
                imem_error = mem_error;
                imem_rdata = mem_rdata;
            end else if (imem_cen) begin
                imem_stall = 1'b1;
            end

            if (grant_d) begin
                mem_cen    = 1'b1;
                mem_wen    = dmem_wen;
                mem_strb   = dmem_strb;
                mem_addr   = dmem_addr;
                mem_wdata  = dmem_wdata;
                arb_owner  = ARB_DMEM;
                dmem_stall = mem_stall;
                dmem_error = mem_error;
                dmem_rdata = mem_rdata;
            end else if (dmem_cen) begin
                dmem_stall = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = UNLOCKED;
        if (!g_reset && grant_any && mem_stall)
            state_nxt = grant_d ? LOCKED_D : LOCKED_I;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state      <= UNLOCKED;
            last_grant <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= (grant_any && !mem_stall) ? grant_d : last_grant;
        end
    end

endmodule

// File: tb/tb_mrv_mem_arbiter.sv
// Directed bench for mrv_mem_arbiter: vector table plus lock/reset/contention sequences.
module tb_mrv_mem_arbiter;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        imem_cen, imem_wen, dmem_cen, dmem_wen;
    logic [3:0]  imem_strb, dmem_strb;
    logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
    logic        imem_stall, imem_error, dmem_stall, dmem_error;
    logic [31:0] imem_rdata, dmem_rdata;
    logic        mem_cen, mem_wen, mem_stall, mem_error;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  arb_owner;

    int checks = 0;
    int errors = 0;

    always #5 g_clk = ~g_clk;

    mrv_mem_arbiter dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .imem_cen(imem_cen), .imem_wen(imem_wen), .imem_strb(imem_strb),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_stall(imem_stall), .imem_error(imem_error), .imem_rdata(imem_rdata),
        .dmem_cen(dmem_cen), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_stall(dmem_stall), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_strb(mem_strb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_error(mem_error), .mem_rdata(mem_rdata),
        .arb_owner(arb_owner)
    );

    typedef struct {
        logic        icen, iwen;
        logic [3:0]  istrb;
        logic [31:0] iaddr, iwdata;
        logic        dcen, dwen;
        logic [3:0]  dstrb;
        logic [31:0] daddr, dwdata;
        logic        merr;
        logic [31:0] mrdata;
        logic        e_cen, e_wen;
        logic [3:0]  e_strb;
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_own;
        logic        e_ist, e_ier;
        logic [31:0] e_ird;
        logic        e_dst, e_der;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Single-word requests for hand sequences; write-side fields held at fixed values.
    task automatic req(input logic icen, input logic [31:0] iaddr,
                       input logic dcen, input logic [31:0] daddr, input logic mstall);
        imem_cen = icen; imem_addr = iaddr; imem_wen = 1'b0; imem_strb = 4'hF; imem_wdata = 32'h0;
        dmem_cen = dcen; dmem_addr = daddr; dmem_wen = 1'b0; dmem_strb = 4'hF; dmem_wdata = 32'h0;
        mem_stall = mstall; mem_error = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk_grant(input string nm, input logic [1:0] own, input logic [31:0] addr,
                             input logic ist, input logic dst);
        @(negedge g_clk);
        chk({nm, ".owner"}, 32'(arb_owner), 32'(own));
        chk({nm, ".mem_cen"}, 32'(mem_cen), (own != 2'd0) ? 32'd1 : 32'd0);
        chk({nm, ".mem_addr"}, mem_addr, addr);
        chk({nm, ".imem_stall"}, 32'(imem_stall), 32'(ist));
        chk({nm, ".dmem_stall"}, 32'(dmem_stall), 32'(dst));
    endtask

    initial begin
        vecs[0] = '{1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'h1111,
                    1'b0,1'b0,4'h0,32'h0,32'h0, 2'd0, 1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0};
        vecs[1] = '{1'b1,1'b0,4'hF,32'h100,32'h0, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b0,32'hDEADBEEF,
                    1'b1,1'b0,4'hF,32'h100,32'h0, 2'd1, 1'b0,1'b0,32'hDEADBEEF, 1'b0,1'b0,32'h0};
        vecs[2] = '{1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b1,4'h3,32'h200,32'hA5A50001, 1'b0,32'h12345678,
                    1'b1,1'b1,4'h3,32'h200,32'hA5A50001, 2'd2, 1'b0,1'b0,32'h0, 1'b0,1'b0,32'h12345678};
        vecs[3] = '{1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,1'b0,4'hF,32'h300,32'h0, 1'b1,32'h00000BAD,
                    1'b1,1'b0,4'hF,32'h300,32'h0, 2'd2, 1'b0,1'b0,32'h0, 1'b0,1'b1,32'h00000BAD};
        vecs[4] = '{1'b1,1'b1,4'hC,32'h104,32'hCAFE0000, 1'b0,1'b0,4'h0,32'h0,32'h0, 1'b1,32'h55,
                    1'b1,1'b1,4'hC,32'h104,32'hCAFE0000, 2'd1, 1'b0,1'b1,32'h55, 1'b0,1'b0,32'h0};
        // Idle requesters with junk on their other inputs must not leak onto the bus.
        vecs[5] = '{1'b0,1'b1,4'hF,32'h999,32'h77, 1'b0,1'b1,4'hF,32'h888,32'h66, 1'b1,32'h4444,
                    1'b0,1'b0,4'h0,32'h0,32'h0, 2'd0, 1'b0,1'b0,32'h0, 1'b0,1'b0,32'h0};

        // Reset held with both requesting: outputs forced to the reset pattern.
        g_reset = 1'b1;
        req(1'b1, 32'h10, 1'b1, 32'h20, 1'b0);
        mem_rdata = 32'hFFFF0000; mem_error = 1'b1;
        next_cycle();
        @(negedge g_clk);
        chk("rst.mem_cen", 32'(mem_cen), 32'd0);
        chk("rst.owner", 32'(arb_owner), 32'd0);
        chk("rst.imem_stall", 32'(imem_stall), 32'd1);
        chk("rst.dmem_stall", 32'(dmem_stall), 32'd1);
        chk("rst.errors", {30'd0, imem_error, dmem_error}, 32'd0);
        chk("rst.rdata", imem_rdata | dmem_rdata, 32'd0);
        next_cycle();
        g_reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            imem_cen = vecs[i].icen; imem_wen = vecs[i].iwen; imem_strb = vecs[i].istrb;
            imem_addr = vecs[i].iaddr; imem_wdata = vecs[i].iwdata;
            dmem_cen = vecs[i].dcen; dmem_wen = vecs[i].dwen; dmem_strb = vecs[i].dstrb;
            dmem_addr = vecs[i].daddr; dmem_wdata = vecs[i].dwdata;
            mem_stall = 1'b0; mem_error = vecs[i].merr; mem_rdata = vecs[i].mrdata;
            @(negedge g_clk);
            chk($sformatf("v%0d.mem_cen", i), 32'(mem_cen), 32'(vecs[i].e_cen));
            chk($sformatf("v%0d.mem_wen", i), 32'(mem_wen), 32'(vecs[i].e_wen));
            chk($sformatf("v%0d.mem_strb", i), 32'(mem_strb), 32'(vecs[i].e_strb));
            chk($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d.owner", i), 32'(arb_owner), 32'(vecs[i].e_own));
            chk($sformatf("v%0d.imem_stall", i), 32'(imem_stall), 32'(vecs[i].e_ist));
            chk($sformatf("v%0d.imem_error", i), 32'(imem_error), 32'(vecs[i].e_ier));
            chk($sformatf("v%0d.imem_rdata", i), imem_rdata, vecs[i].e_ird);
            chk($sformatf("v%0d.dmem_stall", i), 32'(dmem_stall), 32'(vecs[i].e_dst));
            chk($sformatf("v%0d.dmem_error", i), 32'(dmem_error), 32'(vecs[i].e_der));
            chk($sformatf("v%0d.dmem_rdata", i), dmem_rdata, vecs[i].e_drd);
            next_cycle();
        end

        // Back-to-back single-cycle imem transfers, one per cycle.
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 32'h400 + 32'(i * 4), 1'b0, 32'h0, 1'b0);
            chk_grant($sformatf("b2b%0d", i), 2'd1, 32'h400 + 32'(i * 4), 1'b0, 1'b0);
            next_cycle();
        end

        // dmem stalls 3 cycles with imem waiting; dmem keeps the grant for 4 cycles.
        req(1'b0, 32'h0, 1'b1, 32'h500, 1'b1);
        chk_grant("lockd.c1", 2'd2, 32'h500, 1'b0, 1'b1);
        next_cycle();
        req(1'b1, 32'h600, 1'b1, 32'h500, 1'b1);
        chk_grant("lockd.c2", 2'd2, 32'h500, 1'b1, 1'b1);
        next_cycle();
        chk_grant("lockd.c3", 2'd2, 32'h500, 1'b1, 1'b1);
        next_cycle();
        mem_stall = 1'b0;
        chk_grant("lockd.c4", 2'd2, 32'h500, 1'b1, 1'b0);
        next_cycle();
        req(1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
        chk_grant("lockd.c5", 2'd1, 32'h600, 1'b0, 1'b0);
        next_cycle();

        // Lock to imem, hold against dmem, then imem drops cen mid-lock.
        req(1'b1, 32'h700, 1'b0, 32'h0, 1'b1);
        chk_grant("locki.c1", 2'd1, 32'h700, 1'b1, 1'b0);
        next_cycle();
        req(1'b1, 32'h700, 1'b1, 32'h800, 1'b1);
        chk_grant("locki.hold", 2'd1, 32'h700, 1'b1, 1'b1);
        next_cycle();
        req(1'b0, 32'h700, 1'b1, 32'h800, 1'b0);
        chk_grant("locki.drop", 2'd2, 32'h800, 1'b0, 1'b0);
        next_cycle();

        // dmem completes (last_grant=dmem), locks, then reset abandons it.
        req(1'b0, 32'h0, 1'b1, 32'h900, 1'b0);
        next_cycle();
        req(1'b0, 32'h0, 1'b1, 32'h904, 1'b1);
        chk_grant("rstlk.lock", 2'd2, 32'h904, 1'b0, 1'b1);
        next_cycle();
        g_reset = 1'b1;
        @(negedge g_clk);
        chk("rstlk.mem_cen", 32'(mem_cen), 32'd0);
        chk("rstlk.owner", 32'(arb_owner), 32'd0);
        next_cycle();
        g_reset = 1'b0;
        req(1'b1, 32'hA00, 1'b0, 32'h0, 1'b0);
        chk_grant("rstlk.fresh", 2'd1, 32'hA00, 1'b0, 1'b0);
        next_cycle();

        // Contention after reset and an imem completion: last_grant=imem.
        req(1'b1, 32'hB00, 1'b1, 32'hC00, 1'b0);
        chk_grant("cont.c1", 2'd2, 32'hC00, 1'b1, 1'b0);
        next_cycle();
`ifdef MRV_ARB_RR_EN
        chk_grant("cont.c2", 2'd1, 32'hB00, 1'b0, 1'b1);
        next_cycle();
        chk_grant("cont.c3", 2'd2, 32'hC00, 1'b1, 1'b0);
        next_cycle();
        chk_grant("cont.c4", 2'd1, 32'hB00, 1'b0, 1'b1);
`else
        chk_grant("cont.c2", 2'd2, 32'hC00, 1'b1, 1'b0);
        next_cycle();
        chk_grant("cont.c3", 2'd2, 32'hC00, 1'b1, 1'b0);
`endif
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mrv_mem_arbiter.md
MRV_MEM_ARBITER -- requirements
Module: mrv_mem_arbiter

Interface
- REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- REQ-002 g_clk  input  1  single clock; all state updates on rising edge.
- REQ-003 g_reset  input  1  reset, synchronous and active-high.
- REQ-004 imem_cen/imem_wen  input  1/1  instruction requester request, write enable.
- REQ-005 imem_strb/imem_addr/imem_wdata  input  4/32/32  instruction requester strobe, address, write data.
- REQ-006 imem_stall/imem_error  output  1/1; imem_rdata  output  32.
- REQ-007 dmem_* SHALL mirror imem_* exactly, for the data requester.
- REQ-008 mem_cen/mem_wen  output  1/1; mem_strb/mem_addr/mem_wdata  output  4/32/32  shared memory port.
- REQ-009 mem_stall/mem_error  input  1/1; mem_rdata  input  32.
- REQ-010 arb_owner  output  2  current grant: 0 none, 1 imem, 2 dmem.

Function
- REQ-011 A transfer SHALL complete on a cycle with cen=1 and stall=0; rdata and error are valid only on that cycle.
- REQ-012 The grant decision SHALL be combinational in unlocked cycles: zero added latency, and back-to-back single-cycle transfers SHALL sustain one per cycle.
- REQ-013 Granted requester: its addr, wen, strb and wdata SHALL drive mem_*; mem_cen=1; its stall=mem_stall, rdata=mem_rdata, error=mem_error.
- REQ-014 Non-granted requester with cen=1: stall=1, error=0, rdata=0. Idle requester: stall=0, error=0, rdata=0.
- REQ-015 No request pending: mem_cen=0, mem_wen=0, mem_strb=0, mem_addr=0, mem_wdata=0, arb_owner=0.
- REQ-016 State: lock_valid (1b), lock_owner (1b), last_grant (1b).
- REQ-017 States UNLOCKED, LOCKED_I, LOCKED_D. Granted cycle with mem_stall=1 -> LOCKED to that owner. Cycle with mem_stall=0 -> UNLOCKED.
- REQ-018 While LOCKED, the owner SHALL keep the grant whatever the other requester does.
- REQ-019 If the locked owner drops cen (protocol violation), the lock SHALL release that cycle and the grant SHALL be re-decided combinationally.
- REQ-020 Single requester unlocked: it SHALL be granted.
- REQ-021 Simultaneous requests unlocked: resolved per REQ-027 or REQ-028.
- REQ-022 last_grant SHALL update on every completed transfer to the completing owner.

Reset
- REQ-023 On g_reset=1 at a clock edge: lock_valid=0, lock_owner=0, last_grant=imem (0).
- REQ-024 While g_reset=1: mem_cen=0, imem_stall=dmem_stall=1, errors 0, rdata 0, arb_owner=0.
- REQ-025 A reset asserted mid-stall SHALL abandon the transfer; there is no replay.
- REQ-026 The first cycle after reset deasserts SHALL arbitrate normally.

Configuration
- REQ-027 With MRV_ARB_RR_EN defined: round-robin; on contention grant the requester not equal to last_grant.
- REQ-028 Without MRV_ARB_RR_EN: fixed priority; dmem wins contention; last_grant is still kept but does not affect the decision.

Structure
- REQ-029 Shared package mrv_pkg SHALL hold the owner encoding constants (ARB_NONE=0, ARB_IMEM=1, ARB_DMEM=2) and the 2-bit owner typedef.
- REQ-030 Single module; no sub-module. Lock FSM and port mux are both in mrv_mem_arbiter.

Verification
- REQ-031 Only imem requests, addr 0x100, mem_stall=0 -> mem_addr=0x100 same cycle, imem_stall=0, imem_rdata=mem_rdata, arb_owner=1.
- REQ-032 Both request, unlocked, fixed priority -> dmem granted, imem_stall=1. Under MRV_ARB_RR_EN with last_grant=dmem -> imem granted.
- REQ-033 dmem granted, mem_stall=1 for 3 cycles, imem requesting -> dmem keeps the grant for all 4 cycles; imem is granted on cycle 5.
- REQ-034 Locked to imem, imem drops cen while dmem requests -> dmem granted the same cycle, arb_owner=2.
- REQ-035 g_reset pulsed while locked to dmem -> next cycle unlocked, last_grant=imem, mem_cen follows fresh requests.
- REQ-036 Under MRV_ARB_RR_EN, both request continuously, mem_stall=0 -> grants alternate imem/dmem every cycle.
